// File: rtl/matmul_if.sv
// Bundles the matmul_sequencer control, ROM and result-stream signals.
// The master modport is the sequencer side. The slave modport is the ROM and consumer side.
interface matmul_if #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2*DATA_W + $clog2(N)
);
    localparam int AW = $clog2(N*N);
    localparam int RW = $clog2(N);

    logic                     start;
    logic                     busy;
    logic                     done;
    logic        [AW-1:0]     a_addr;
    logic        [AW-1:0]     b_addr;
    logic signed [DATA_W-1:0] a_data;
    logic signed [DATA_W-1:0] b_data;
    logic                     c_valid;
    logic                     c_ready;
    logic signed [ACC_W-1:0]  c_data;
    logic        [RW-1:0]     c_row;
    logic        [RW-1:0]     c_col;

    modport master (
        input  start, a_data, b_data, c_ready,
        output busy, done, a_addr, b_addr, c_valid, c_data, c_row, c_col
    );

    modport slave (
        output start, a_data, b_data, c_ready,
        input  busy, done, a_addr, b_addr, c_valid, c_data, c_row, c_col
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences an NxN signed matrix multiply C = A*B over two 1-cycle ROMs.
// Each C element is streamed out in row-major order on a valid/ready handshake.
module matmul_sequencer #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 2*DATA_W + $clog2(N)
) (
    input  logic      clk,
    input  logic      rst,
    matmul_if.master  bus
);
    localparam int AW = $clog2(N*N);
    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] LAST_IDX = RW'(N-1);
    localparam logic [AW-1:0] N_AW     = AW'(N);

    typedef enum logic [2:0] {IDLE, RUN, LAST, OUT, DONE} state_t;

    state_t                   state, state_nxt;
    logic        [RW-1:0]     r, c, k;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic                     last_k, last_elem, accept;

    assign last_k    = (k == LAST_IDX);
    assign last_elem = (r == LAST_IDX) && (c == LAST_IDX);
    assign accept    = (state == OUT) && bus.c_ready;

    // Both operands are widened first so the product keeps full signed precision.
    assign a_ext = {{DATA_W{bus.a_data[DATA_W-1]}}, bus.a_data};
    assign b_ext = {{DATA_W{bus.b_data[DATA_W-1]}}, bus.b_data};
    assign prod  = a_ext * b_ext;

    assign bus.a_addr  = (state == RUN) ? AW'(r) * N_AW + AW'(k) : '0;
    assign bus.b_addr  = (state == RUN) ? AW'(k) * N_AW + AW'(c) : '0;
    assign bus.c_data  = acc;
    assign bus.c_row   = r;
    assign bus.c_col   = c;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        bus.c_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = RUN;
            end
            RUN:  if (last_k) state_nxt = LAST;
            LAST: state_nxt = OUT;
            OUT: begin
                bus.c_valid = 1'b1;
                if (bus.c_ready) state_nxt = last_elem ? DONE : RUN;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The ROM data lags the address by one cycle, so mac_en trails the RUN state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r      <= '0;
            c      <= '0;
            k      <= '0;
            acc    <= '0;
            mac_en <= 1'b0;
        end else begin
            mac_en <= (state == RUN);
            if (state == IDLE && bus.start) begin
                r   <= '0;
                c   <= '0;
                k   <= '0;
                acc <= '0;
            end
            if (state == RUN) k <= last_k ? '0 : k + RW'(1);
            if (mac_en) acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            if (accept) begin
                acc <= '0;
                k   <= '0;
                if (c == LAST_IDX) begin
                    c <= '0;
                    r <= (r == LAST_IDX) ? '0 : r + RW'(1);
                end else begin
                    c <= c + RW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer, using ROM models and a matrix reference model.
// It covers directed and random matrices, backpressure, start while busy and an abort by reset.
module tb_matmul_sequencer;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int CW = 2*DW + $clog2(N);
    localparam int NN = N*N;
    localparam longint MAXPOS = 64'sd4294705156;
    localparam longint MAXNEG = -64'sd4294836224;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic signed [DW-1:0] aMem [NN];
    logic signed [DW-1:0] bMem [NN];
    logic signed [CW-1:0] expC [NN];

    matmul_if #(.N(N), .DATA_W(DW), .ACC_W(CW)) bus ();

    matmul_sequencer #(.N(N), .DATA_W(DW), .ACC_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.a_data <= aMem[bus.a_addr];
        bus.b_data <= bMem[bus.b_addr];
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void buildModel();
        longint s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int m = 0; m < N; m++)
                    s += longint'(aMem[i*N+m]) * longint'(bMem[m*N+j]);
                expC[i*N+j] = s[CW-1:0];
            end
    endfunction

    task automatic loadRandom();
        for (int i = 0; i < NN; i++) begin
            aMem[i] = DW'($urandom);
            bMem[i] = DW'($urandom);
        end
        buildModel();
    endtask

    task automatic applyReset();
        bus.start   = 1'b0;
        bus.c_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one multiply from a start pulse and checks every streamed element against expC.
    task automatic applyStimulus(input string name, input bit randReady, input bit holdStart,
                                 input int stallElem, input int pokeElem, input int abortElem);
        int idx = 0, doneCnt = 0, lastAcc = -1, stallCnt = 0, noisy = 0;
        bit poked = 1'b0, finished = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                if (!holdStart) bus.start = 1'b0;
            end
            if (!poked && idx == pokeElem && bus.busy && !bus.c_valid) begin
                bus.start = 1'b1;
                poked = 1'b1;
            end
            if (idx == abortElem && cyc == lastAcc + 3) begin
                applyReset();
                checkOutput({name, " abort busy"},    bus.busy,    0);
                checkOutput({name, " abort c_valid"}, bus.c_valid, 0);
                checkOutput({name, " abort a_addr"},  bus.a_addr,  0);
                checkOutput({name, " abort b_addr"},  bus.b_addr,  0);
                checkOutput({name, " abort done"},    bus.done,    0);
                repeat (10) begin
                    @(negedge clk);
                    if (bus.busy || bus.done || bus.c_valid) noisy++;
                end
                checkOutput({name, " abort quiet"}, noisy, 0);
                return;
            end
            if (idx == stallElem && bus.c_valid && stallCnt < 5) begin
                bus.c_ready = 1'b0;
                stallCnt++;
                checkOutput({name, " stall data"},   bus.c_data, expC[idx]);
                checkOutput({name, " stall row"},    bus.c_row,  idx / N);
                checkOutput({name, " stall col"},    bus.c_col,  idx % N);
                checkOutput({name, " stall a_addr"}, bus.a_addr, 0);
                checkOutput({name, " stall b_addr"}, bus.b_addr, 0);
            end else begin
                bus.c_ready = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (bus.c_valid && bus.c_ready) begin
                if (idx < NN) begin
                    checkOutput({name, " data"}, bus.c_data, expC[idx]);
                    checkOutput({name, " row"},  bus.c_row,  idx / N);
                    checkOutput({name, " col"},  bus.c_col,  idx % N);
                    if (!randReady)
                        checkOutput({name, " latency"}, cyc, (N+2)*(idx+1) + stallCnt);
                end else begin
                    checkOutput({name, " overrun"}, idx, NN-1);
                end
                lastAcc = cyc;
                idx++;
            end
            if (bus.done) begin
                doneCnt++;
                checkOutput({name, " done timing"}, cyc, lastAcc + 1);
                finished = 1'b1;
            end
        end
        checkOutput({name, " elements"},    idx,     NN);
        checkOutput({name, " done pulses"}, doneCnt, 1);
        @(negedge clk);
        checkOutput({name, " done width"}, bus.done, 0);
        checkOutput({name, " idle busy"},  bus.busy, 0);
        if (holdStart) begin
            @(negedge clk);
            checkOutput({name, " restart busy"}, bus.busy, 1);
            applyReset();
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.c_ready = 1'b0;
        for (int i = 0; i < NN; i++) begin
            aMem[i] = '0;
            bMem[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset busy",    bus.busy,    0);
        checkOutput("reset done",    bus.done,    0);
        checkOutput("reset c_valid", bus.c_valid, 0);
        checkOutput("reset a_addr",  bus.a_addr,  0);
        checkOutput("reset b_addr",  bus.b_addr,  0);
        checkOutput("reset c_data",  bus.c_data,  0);
        checkOutput("reset c_row",   bus.c_row,   0);
        checkOutput("reset c_col",   bus.c_col,   0);

        $display("[TB] identity times sequence");
        for (int i = 0; i < NN; i++) begin
            aMem[i] = (i / N == i % N) ? DW'(1) : DW'(0);
            bMem[i] = DW'(i + 1);
            expC[i] = CW'(i + 1);
        end
        applyStimulus("ident", 1'b0, 1'b0, -1, -1, -1);

        $display("[TB] extreme operands");
        for (int i = 0; i < NN; i++) begin
            aMem[i] = 16'sh7FFF;
            bMem[i] = 16'sh7FFF;
            expC[i] = CW'(MAXPOS);
        end
        applyStimulus("maxpos", 1'b0, 1'b0, -1, -1, -1);
        for (int i = 0; i < NN; i++) begin
            aMem[i] = 16'sh8000;
            expC[i] = CW'(MAXNEG);
        end
        applyStimulus("maxneg", 1'b0, 1'b0, -1, -1, -1);

        $display("[TB] backpressure, start while busy, abort");
        loadRandom();
        applyStimulus("stall", 1'b0, 1'b0, 1, -1, -1);
        loadRandom();
        applyStimulus("poke", 1'b0, 1'b0, -1, 6, -1);
        loadRandom();
        applyStimulus("abort", 1'b0, 1'b0, -1, -1, 8);
        applyStimulus("after abort", 1'b0, 1'b0, -1, -1, -1);

        $display("[TB] start held high and random backpressure");
        loadRandom();
        applyStimulus("hold start", 1'b0, 1'b1, -1, -1, -1);
        for (int t = 0; t < 3; t++) begin
            loadRandom();
            applyStimulus("random ready", 1'b1, 1'b0, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
